// File: rtl/assoc_wb_cache.sv
// assoc_wb_cache
// N-way set-associative, write-back, write-allocate, blocking cache. It sits between a
// word-wide higher-level (hc) port and a line-wide lower-level (lc) port. Misses use
// round-robin replacement and write back a dirty victim first. A flush walk writes back
// every dirty line and leaves all lines valid.
//
// Ports:
//   clk_in, rst_in        clock, asynchronous active-high reset
//   cs_in                 chip select, gates acceptance of new hc requests
//   flush_in              start a flush walk (only honoured in IDLE, wins over a request)
//   flush_done_out        one-cycle pulse at the end of the flush walk
//   hc_valid_in/ready_out, hc_addr_in, hc_value_in, hc_we_in    request channel
//   hc_valid_out/ready_in, hc_addr_out, hc_value_out, hc_we_out response channel
//   lc_valid_out/ready_in, lc_addr_out, lc_value_out, lc_we_out lower-level request (write-back or fill read)
//   lc_valid_in/ready_out, lc_addr_in, lc_value_in              lower-level fill return
//
// Handshake rule on every channel: a transfer happens on the rising clock edge where valid
// and ready are both high. Once raised, valid and its payload stay stable until that edge.
// The FSM state is held in state_q.
module assoc_wb_cache #(
    parameter int W        = 64,
    parameter int DATA_W   = 64,
    parameter int LINE_W   = 512,
    parameter int NUM_SETS = 64,
    parameter int NUM_WAYS = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              cs_in,
    input  logic              flush_in,
    output logic              flush_done_out,
    input  logic              hc_valid_in,
    output logic              hc_ready_out,
    input  logic [W-1:0]      hc_addr_in,
    input  logic [DATA_W-1:0] hc_value_in,
    input  logic              hc_we_in,
    output logic              hc_valid_out,
    input  logic              hc_ready_in,
    output logic [W-1:0]      hc_addr_out,
    output logic [DATA_W-1:0] hc_value_out,
    output logic              hc_we_out,
    output logic              lc_valid_out,
    input  logic              lc_ready_in,
    output logic [W-1:0]      lc_addr_out,
    output logic [LINE_W-1:0] lc_value_out,
    output logic              lc_we_out,
    input  logic              lc_valid_in,
    output logic              lc_ready_out,
    input  logic [W-1:0]      lc_addr_in,
    input  logic [LINE_W-1:0] lc_value_in
);
    localparam int OFF  = $clog2(LINE_W / 8);
    localparam int IDX  = $clog2(NUM_SETS);
    localparam int TAG  = W - OFF - IDX;
    localparam int BOFF = $clog2(DATA_W / 8);
    localparam int WSEL = OFF - BOFF;
    localparam int WAYB = $clog2(NUM_WAYS);
    localparam int CNTW = IDX + WAYB;

    typedef enum logic [3:0] {
        IDLE, LOOKUP, RESPOND, WRITEBACK, FILL_REQ, FILL_WAIT, FLUSH_SCAN, FLUSH_WB, FLUSH_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [W-1:0]        req_addr_q, req_addr_d;
    logic [DATA_W-1:0]   req_value_q, req_value_d;
    logic                req_we_q, req_we_d;
    logic [DATA_W-1:0]   resp_value_q, resp_value_d;
    logic [WAYB-1:0]     victim_q, victim_d;
    logic [CNTW-1:0]     flush_cnt_q, flush_cnt_d;

    logic                valid_q  [NUM_SETS][NUM_WAYS];
    logic                dirty_q  [NUM_SETS][NUM_WAYS];
    logic [WAYB-1:0]     rr_ptr_q [NUM_SETS];
    logic [TAG-1:0]      tag_q    [NUM_SETS][NUM_WAYS];
    logic [LINE_W-1:0]   data_q   [NUM_SETS][NUM_WAYS];

    logic [IDX-1:0]      req_idx, fl_set, wb_set;
    logic [TAG-1:0]      req_tag;
    logic [WSEL-1:0]     req_word;
    logic [WAYB-1:0]     fl_way, wb_way, hit_way, inv_way;
    logic                hit, inv_found, wb_active;
    logic [LINE_W-1:0]   hit_line, merged_line;
    logic                fill_en, wr_en, clr_en, rr_inc_en;
    logic                unused_lc_bits;

    assign req_idx  = req_addr_q[OFF +: IDX];
    assign req_tag  = req_addr_q[W-1 -: TAG];
    assign req_word = req_addr_q[BOFF +: WSEL];
    // Flush counter is set-major: {set, way}, so ways of one set are visited together.
    assign fl_set   = flush_cnt_q[CNTW-1 -: IDX];
    assign fl_way   = flush_cnt_q[WAYB-1:0];
    assign wb_active = (state_q == WRITEBACK) || (state_q == FLUSH_WB);
    assign wb_set   = (state_q == FLUSH_WB) ? fl_set : req_idx;
    assign wb_way   = (state_q == FLUSH_WB) ? fl_way : victim_q;
    assign unused_lc_bits = ^lc_addr_in[OFF-1:0];

    // Parallel tag compare, plus the lowest-index invalid way for allocation.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!hit && valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAYB'(w);
            end
            if (!inv_found && !valid_q[req_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAYB'(w);
            end
        end
    end

    assign hit_line = data_q[req_idx][hit_way];

    always_comb begin
        merged_line = hit_line;
        merged_line[req_word*DATA_W +: DATA_W] = req_value_q;
    end

    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        req_value_d  = req_value_q;
        req_we_d     = req_we_q;
        resp_value_d = resp_value_q;
        victim_d     = victim_q;
        flush_cnt_d  = flush_cnt_q;
        fill_en      = 1'b0;
        wr_en        = 1'b0;
        clr_en       = 1'b0;
        rr_inc_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_in) begin
                    flush_cnt_d = '0;
                    state_d     = FLUSH_SCAN;
                end else if (hc_valid_in && hc_ready_out) begin
                    req_addr_d  = hc_addr_in;
                    req_value_d = hc_value_in;
                    req_we_d    = hc_we_in;
                    state_d     = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    if (req_we_q) begin
                        wr_en        = 1'b1;
                        resp_value_d = req_value_q;
                    end else begin
                        resp_value_d = hit_line[req_word*DATA_W +: DATA_W];
                    end
                    state_d = RESPOND;
                end else if (inv_found) begin
                    // An invalid way is never dirty, so no write-back is needed.
                    victim_d = inv_way;
                    state_d  = FILL_REQ;
                end else begin
                    victim_d  = rr_ptr_q[req_idx];
                    rr_inc_en = 1'b1;
                    state_d   = dirty_q[req_idx][rr_ptr_q[req_idx]] ? WRITEBACK : FILL_REQ;
                end
            end
            RESPOND:   if (hc_ready_in) state_d = IDLE;
            WRITEBACK: begin
                if (lc_ready_in) begin
                    clr_en  = 1'b1;
                    state_d = FILL_REQ;
                end
            end
            FILL_REQ:  if (lc_ready_in) state_d = FILL_WAIT;
            FILL_WAIT: begin
                // A fill for some other line is accepted and dropped.
                if (lc_valid_in && (lc_addr_in[W-1:OFF] == req_addr_q[W-1:OFF])) begin
                    fill_en = 1'b1;
                    state_d = LOOKUP;
                end
            end
            FLUSH_SCAN: begin
                if (valid_q[fl_set][fl_way] && dirty_q[fl_set][fl_way]) begin
                    state_d = FLUSH_WB;
                end else if (flush_cnt_q == '1) begin
                    state_d = FLUSH_DONE;
                end else begin
                    flush_cnt_d = flush_cnt_q + CNTW'(1);
                end
            end
            FLUSH_WB: begin
                if (lc_ready_in) begin
                    clr_en = 1'b1;
                    if (flush_cnt_q == '1) begin
                        state_d = FLUSH_DONE;
                    end else begin
                        flush_cnt_d = flush_cnt_q + CNTW'(1);
                        state_d     = FLUSH_SCAN;
                    end
                end
            end
            FLUSH_DONE: state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            req_addr_q   <= '0;
            req_value_q  <= '0;
            req_we_q     <= 1'b0;
            resp_value_q <= '0;
            victim_q     <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            req_addr_q   <= req_addr_d;
            req_value_q  <= req_value_d;
            req_we_q     <= req_we_d;
            resp_value_q <= resp_value_d;
            victim_q     <= victim_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                rr_ptr_q[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                end
            end
        end else begin
            if (fill_en) begin
                valid_q[req_idx][victim_q] <= 1'b1;
                dirty_q[req_idx][victim_q] <= 1'b0;
            end
            if (wr_en)     dirty_q[req_idx][hit_way] <= 1'b1;
            if (clr_en)    dirty_q[wb_set][wb_way]   <= 1'b0;
            if (rr_inc_en) rr_ptr_q[req_idx]         <= rr_ptr_q[req_idx] + WAYB'(1);
        end
    end

    // Tag and data arrays need no reset; valid bits qualify them.
    always_ff @(posedge clk_in) begin
        if (fill_en) begin
            tag_q[req_idx][victim_q]  <= req_tag;
            data_q[req_idx][victim_q] <= lc_value_in;
        end
        if (wr_en) data_q[req_idx][hit_way] <= merged_line;
    end

    // Outputs decode the asynchronously reset state, so they drop together with rst_in.
    assign hc_ready_out   = (state_q == IDLE) && cs_in && !flush_in;
    assign hc_valid_out   = (state_q == RESPOND);
    assign hc_addr_out    = req_addr_q;
    assign hc_value_out   = resp_value_q;
    assign hc_we_out      = req_we_q;
    assign lc_valid_out   = wb_active || (state_q == FILL_REQ);
    assign lc_we_out      = wb_active;
    assign lc_addr_out    = wb_active ? {tag_q[wb_set][wb_way], wb_set, {OFF{1'b0}}} :
                            (state_q == FILL_REQ) ? {req_addr_q[W-1:OFF], {OFF{1'b0}}} : '0;
    assign lc_value_out   = wb_active ? data_q[wb_set][wb_way] : '0;
    assign lc_ready_out   = (state_q == FILL_WAIT);
    assign flush_done_out = (state_q == FLUSH_DONE);
endmodule

// File: tb/tb_assoc_wb_cache.sv
// Directed bench for assoc_wb_cache with default parameters. A behavioural lower level
// answers fill reads and records every lc request. Expected hc responses are queued when
// a request is driven and checked when the response appears.
module tb_assoc_wb_cache;
    logic         clk = 1'b0;
    logic         rst_in, cs_in, flush_in, flush_done_out;
    logic         hc_valid_in, hc_ready_out, hc_we_in, hc_valid_out, hc_ready_in, hc_we_out;
    logic [63:0]  hc_addr_in, hc_value_in, hc_addr_out, hc_value_out;
    logic         lc_valid_out, lc_ready_in, lc_we_out, lc_valid_in, lc_ready_out;
    logic [63:0]  lc_addr_out, lc_addr_in;
    logic [511:0] lc_value_out, lc_value_in;

    int tests_run = 0;
    int failures  = 0;
    logic [63:0]  exp_q[$];
    logic         exp_we_q[$];
    logic [63:0]  lc_addr_log[$];
    logic         lc_we_log[$];
    logic [511:0] lc_val_log[$];

    assoc_wb_cache dut (
        .clk_in(clk), .rst_in(rst_in), .cs_in(cs_in), .flush_in(flush_in),
        .flush_done_out(flush_done_out),
        .hc_valid_in(hc_valid_in), .hc_ready_out(hc_ready_out), .hc_addr_in(hc_addr_in),
        .hc_value_in(hc_value_in), .hc_we_in(hc_we_in),
        .hc_valid_out(hc_valid_out), .hc_ready_in(hc_ready_in), .hc_addr_out(hc_addr_out),
        .hc_value_out(hc_value_out), .hc_we_out(hc_we_out),
        .lc_valid_out(lc_valid_out), .lc_ready_in(lc_ready_in), .lc_addr_out(lc_addr_out),
        .lc_value_out(lc_value_out), .lc_we_out(lc_we_out),
        .lc_valid_in(lc_valid_in), .lc_ready_out(lc_ready_out), .lc_addr_in(lc_addr_in),
        .lc_value_in(lc_value_in)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        lc_addr_log.delete();
        lc_we_log.delete();
        lc_val_log.delete();
    endtask

    task automatic log_lc();
        if (lc_valid_out && lc_ready_in) begin
            lc_addr_log.push_back(lc_addr_out);
            lc_we_log.push_back(lc_we_out);
            lc_val_log.push_back(lc_value_out);
        end
    endtask

    // Drives one hc request, plays the lower level, checks the response.
    task automatic do_access(input logic [63:0] addr, input logic we, input logic [63:0] wdata,
                             input logic [63:0] exp, input logic [511:0] fill,
                             input int stall, input bit bogus, output int lat);
        int cyc;
        int held;
        bit seen;
        bit done;
        bit bogus_left;
        logic [63:0] snap_val;
        logic [63:0] snap_addr;
        logic        snap_we;
        exp_q.push_back(exp);
        exp_we_q.push_back(we);
        lat = -1;
        seen = 1'b0;
        done = 1'b0;
        held = 0;
        bogus_left = bogus;
        snap_val = '0;
        snap_addr = '0;
        snap_we = 1'b0;
        @(negedge clk);
        hc_addr_in  = addr;
        hc_we_in    = we;
        hc_value_in = wdata;
        hc_valid_in = 1'b1;
        hc_ready_in = (stall == 0);
        #1;
        cyc = 0;
        while (!hc_ready_out && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        cyc = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            hc_valid_in = 1'b0;
            lc_valid_in = 1'b0;
            log_lc();
            if (lc_ready_out) begin
                lc_valid_in = 1'b1;
                lc_value_in = fill;
                if (bogus_left) begin
                    lc_addr_in = (addr & ~64'h3F) ^ 64'h100000;
                    bogus_left = 1'b0;
                end else begin
                    lc_addr_in = addr & ~64'h3F;
                end
            end
            if (hc_valid_out) begin
                if (!seen) begin
                    seen = 1'b1;
                    lat = cyc;
                    snap_val = hc_value_out;
                    snap_addr = hc_addr_out;
                    snap_we = hc_we_out;
                    check("hc_value", hc_value_out, exp_q.pop_front());
                    check("hc_we_echo", hc_we_out, exp_we_q.pop_front());
                    check("hc_addr_echo", hc_addr_out, addr);
                end else begin
                    check("stall_value_stable", hc_value_out, snap_val);
                    check("stall_addr_stable", hc_addr_out, snap_addr);
                    check("stall_we_stable", hc_we_out, snap_we);
                end
                if (held >= stall) begin
                    hc_ready_in = 1'b1;
                    done = 1'b1;
                end else begin
                    held++;
                end
            end
        end
        check("hc_resp_timeout", seen, 1'b1);
        if (!seen) begin
            void'(exp_q.pop_front());
            void'(exp_we_q.pop_front());
        end
    endtask

    task automatic do_flush(output int done_cnt);
        int cyc;
        int tail;
        done_cnt = 0;
        @(negedge clk);
        flush_in = 1'b1;
        #1;
        check("ready_blocked_by_flush", hc_ready_out, 1'b0);
        @(negedge clk);
        flush_in = 1'b0;
        cyc = 0;
        tail = -1;
        while (cyc < 600 && tail != 0) begin
            @(negedge clk);
            cyc++;
            log_lc();
            if (flush_done_out) begin
                done_cnt++;
                tail = 3;
            end else if (tail > 0) begin
                tail--;
            end
        end
        check("flush_timeout", (tail == 0), 1'b1);
    endtask

    initial begin
        int lat;
        int dn;
        int cyc;
        rst_in = 1'b1; cs_in = 1'b0; flush_in = 1'b0;
        hc_valid_in = 1'b0; hc_addr_in = '0; hc_value_in = '0; hc_we_in = 1'b0; hc_ready_in = 1'b1;
        lc_ready_in = 1'b1; lc_valid_in = 1'b0; lc_addr_in = '0; lc_value_in = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_hc_valid", hc_valid_out, 1'b0);
        check("rst_lc_valid", lc_valid_out, 1'b0);
        check("rst_lc_ready", lc_ready_out, 1'b0);
        check("rst_flush_done", flush_done_out, 1'b0);
        check("rst_hc_ready", hc_ready_out, 1'b0);
        check("rst_lc_addr", lc_addr_out, 64'h0);
        check("rst_lc_value", lc_value_out, 512'h0);
        rst_in = 1'b0;
        @(negedge clk);
        check("cs_low_blocks", hc_ready_out, 1'b0);
        cs_in = 1'b1;
        #1;
        check("cs_high_ready", hc_ready_out, 1'b1);

        // 1: cold miss then hit
        clear_log();
        do_access(64'h0, 1'b0, 64'h0, 64'h0123456789ABCDEF, 512'h0123456789ABCDEF, 0, 1'b0, lat);
        check("t1_miss_latency", lat, 5);
        check("t1_lc_count", lc_addr_log.size(), 1);
        check("t1_lc_we", lc_we_log[0], 1'b0);
        check("t1_lc_addr", lc_addr_log[0], 64'h0);
        clear_log();
        do_access(64'h0, 1'b0, 64'h0, 64'h0123456789ABCDEF, 512'h0, 0, 1'b0, lat);
        check("t1_hit_latency", lat, 2);
        check("t1_hit_no_lc", lc_addr_log.size(), 0);

        // 2: fill ways 1-3 of set 0 (first with a stray fill beat), then re-read all
        do_access(64'h4000, 1'b0, 64'h0, 64'h1111111111111111, 512'h1111111111111111, 0, 1'b1, lat);
        do_access(64'h34000, 1'b0, 64'h0, 64'h2222222222222222, 512'h2222222222222222, 0, 1'b0, lat);
        do_access(64'h44000, 1'b0, 64'h0, 64'h3333333333333333, 512'h3333333333333333, 0, 1'b0, lat);
        clear_log();
        do_access(64'h0, 1'b0, 64'h0, 64'h0123456789ABCDEF, 512'h0, 0, 1'b0, lat);
        do_access(64'h4000, 1'b0, 64'h0, 64'h1111111111111111, 512'h0, 0, 1'b0, lat);
        do_access(64'h34000, 1'b0, 64'h0, 64'h2222222222222222, 512'h0, 0, 1'b0, lat);
        do_access(64'h44000, 1'b0, 64'h0, 64'h3333333333333333, 512'h0, 0, 1'b0, lat);
        check("t2_no_lc_traffic", lc_addr_log.size(), 0);

        // 3: write hit into word 1 of line 0
        do_access(64'h8, 1'b1, 64'hFEDCBA9876543210, 64'hFEDCBA9876543210, 512'h0, 0, 1'b0, lat);
        check("t3_write_hit_latency", lat, 2);
        do_access(64'h8, 1'b0, 64'h0, 64'hFEDCBA9876543210, 512'h0, 0, 1'b0, lat);
        do_access(64'h0, 1'b0, 64'h0, 64'h0123456789ABCDEF, 512'h0, 0, 1'b0, lat);
        check("t3_no_lc_traffic", lc_addr_log.size(), 0);

        // 4: set full, way 0 dirty -> write-back then fill
        do_access(64'h54000, 1'b0, 64'h0, 64'h5555555555555555, 512'h5555555555555555, 0, 1'b0, lat);
        check("t4_latency", lat, 6);
        check("t4_lc_count", lc_addr_log.size(), 2);
        check("t4_wb_we", lc_we_log[0], 1'b1);
        check("t4_wb_addr", lc_addr_log[0], 64'h0);
        check("t4_wb_line", lc_val_log[0], {384'h0, 64'hFEDCBA9876543210, 64'h0123456789ABCDEF});
        check("t4_fill_we", lc_we_log[1], 1'b0);
        check("t4_fill_addr", lc_addr_log[1], 64'h54000);
        check("t4_rr_ptr", dut.rr_ptr_q[0], 2'd1);

        // 5: dirty lines in sets 0 and 5, flush twice
        do_access(64'h4000, 1'b1, 64'hAAAA000000004000, 64'hAAAA000000004000, 512'h0, 0, 1'b0, lat);
        do_access(64'h140, 1'b1, 64'h5555000000000140, 64'h5555000000000140, 512'h0, 0, 1'b0, lat);
        check("t5_write_miss_latency", lat, 5);
        clear_log();
        do_flush(dn);
        check("t5_flush_writes", lc_addr_log.size(), 2);
        check("t5_flush_done_pulses", dn, 1);
        check("t5_wb0_addr", lc_addr_log[0], 64'h4000);
        check("t5_wb0_we", lc_we_log[0], 1'b1);
        check("t5_wb0_word", lc_val_log[0][63:0], 64'hAAAA000000004000);
        check("t5_wb1_addr", lc_addr_log[1], 64'h140);
        check("t5_wb1_word", lc_val_log[1][63:0], 64'h5555000000000140);
        clear_log();
        do_flush(dn);
        check("t5_second_flush_writes", lc_addr_log.size(), 0);
        check("t5_second_flush_done", dn, 1);
        do_access(64'h4000, 1'b0, 64'h0, 64'hAAAA000000004000, 512'h0, 0, 1'b0, lat);
        check("t5_valid_after_flush", lat, 2);

        // 6a: response held stable while hc_ready_in is low
        do_access(64'h34000, 1'b0, 64'h0, 64'h2222222222222222, 512'h0, 3, 1'b0, lat);

        // 6b: reset while a write-back is pending
        do_access(64'h4000, 1'b1, 64'hBBBB000000004000, 64'hBBBB000000004000, 512'h0, 0, 1'b0, lat);
        lc_ready_in = 1'b0;
        @(negedge clk);
        hc_addr_in = 64'h64000; hc_we_in = 1'b0; hc_valid_in = 1'b1;
        @(negedge clk);
        hc_valid_in = 1'b0;
        cyc = 0;
        while (!(lc_valid_out && lc_we_out) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("t6_wb_reached", (lc_valid_out && lc_we_out), 1'b1);
        check("t6_wb_addr", lc_addr_out, 64'h4000);
        #2 rst_in = 1'b1;
        #1;
        check("t6_rst_lc_valid_async", lc_valid_out, 1'b0);
        check("t6_rst_hc_valid", hc_valid_out, 1'b0);
        @(negedge clk);
        rst_in = 1'b0;
        lc_ready_in = 1'b1;
        clear_log();
        do_access(64'h0, 1'b0, 64'h0, 64'h0F0F0F0F0F0F0F0F, 512'h0F0F0F0F0F0F0F0F, 0, 1'b0, lat);
        check("t6_post_rst_miss_latency", lat, 5);
        check("t6_post_rst_lc_count", lc_addr_log.size(), 1);
        check("t6_post_rst_fill_addr", lc_addr_log[0], 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end
endmodule
